// File: rtl/inst_queue_pkg.sv
// Shared configuration and types for the fetch-to-decode instruction queue.
// IQ_DEPTH and EXC_W provide the default depth and exception-code width.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int EXC_W    = 8;
  localparam int INSTR_W  = 32;

  typedef enum logic [1:0] {
    OP_NORMAL   = 2'd0,
    OP_FLUSH    = 2'd1,
    OP_REDIRECT = 2'd2
  } qOp_e;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue.
// The fetch/decode side uses master; the queue uses slave.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int IW    = INSTR_W,
  parameter int EW    = EXC_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [IW-1:0] push_pc;
  logic [IW-1:0] push_instr;
  logic [EW-1:0] push_exc;
  logic          pop;
  logic          flush;
  logic          redirect;

  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          head_valid;
  logic [IW-1:0] head_pc;
  logic [IW-1:0] head_instr;
  logic [EW-1:0] head_exc;
  logic          head_ds;
  logic          ds_missing;

  modport master (
    output push, push_pc, push_instr, push_exc, pop, flush, redirect,
    input  full, empty, count, head_valid, head_pc, head_instr, head_exc,
           head_ds, ds_missing
  );

  modport slave (
    input  push, push_pc, push_instr, push_exc, pop, flush, redirect,
    output full, empty, count, head_valid, head_pc, head_instr, head_exc,
           head_ds, ds_missing
  );

endinterface

// File: rtl/inst_queue.sv
// Show-ahead instruction queue between fetch and decode, with flush and
// branch-redirect handling that preserves (or later tags) the delay slot.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int IW    = INSTR_W,
  parameter int EW    = EXC_W
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0]    pcMem    [DEPTH];
  logic [IW-1:0]    instrMem [DEPTH];
  logic [EW-1:0]    excMem   [DEPTH];
  logic [DEPTH-1:0] dsMem;

  logic [PW-1:0] rdPtr, wrPtr, rdPtrNext, wrPtrNext, markPtr;
  logic [CW-1:0] cnt, cntNext;
  logic          dsPending, dsPendingNext;
  logic          dsMissing, dsMissingNext;
  logic          wrEn, wrDs, dsMark;
  logic          isEmpty, isFull, popOk, pushOk;
  qOp_e          op;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CW'(DEPTH));
  assign popOk   = q.pop && !isEmpty;
  assign pushOk  = q.push && (!isFull || q.pop);
  assign markPtr = rdPtr + PW'(1);

  always_comb begin
    op            = OP_NORMAL;
    rdPtrNext     = rdPtr;
    wrPtrNext     = wrPtr;
    cntNext       = cnt;
    dsPendingNext = dsPending;
    dsMissingNext = 1'b0;
    wrEn          = 1'b0;
    wrDs          = dsPending;
    dsMark        = 1'b0;

    if (q.flush)
      op = OP_FLUSH;
    else if (q.redirect && popOk)
      op = OP_REDIRECT;

    case (op)
      OP_FLUSH: begin
        rdPtrNext     = '0;
        wrPtrNext     = '0;
        cntNext       = '0;
        dsPendingNext = 1'b0;
      end
      OP_REDIRECT: begin
        rdPtrNext = rdPtr + PW'(1);
        if (cnt != CW'(1)) begin
          // Delay slot already queued behind the branch: keep it alone.
          dsMark    = 1'b1;
          wrPtrNext = rdPtr + PW'(2);
          cntNext   = CW'(1);
        end else if (q.push) begin
          wrEn          = 1'b1;
          wrDs          = 1'b1;
          wrPtrNext     = wrPtr + PW'(1);
          cntNext       = CW'(1);
          dsPendingNext = 1'b0;
        end else begin
          cntNext       = '0;
          dsMissingNext = 1'b1;
          dsPendingNext = 1'b1;
        end
      end
      default: begin
        wrEn = pushOk;
        if (pushOk) begin
          wrPtrNext     = wrPtr + PW'(1);
          dsPendingNext = 1'b0;
        end
        if (popOk)
          rdPtrNext = rdPtr + PW'(1);
        cntNext = cnt + CW'(pushOk) - CW'(popOk);
      end
    endcase
  end

  // Storage: data flops carry no reset; visibility is gated by occupancy.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      pcMem[wrPtr]    <= q.push_pc;
      instrMem[wrPtr] <= q.push_instr;
      excMem[wrPtr]   <= q.push_exc;
      dsMem[wrPtr]    <= wrDs;
    end
    if (dsMark)
      dsMem[markPtr] <= 1'b1;
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      cnt       <= '0;
      dsPending <= 1'b0;
      dsMissing <= 1'b0;
    end else begin
      rdPtr     <= rdPtrNext;
      wrPtr     <= wrPtrNext;
      cnt       <= cntNext;
      dsPending <= dsPendingNext;
      dsMissing <= dsMissingNext;
    end
  end

  assign q.count      = cnt;
  assign q.empty      = isEmpty;
  assign q.full       = isFull;
  assign q.head_valid = !isEmpty;
  assign q.head_pc    = isEmpty ? '0 : pcMem[rdPtr];
  assign q.head_instr = isEmpty ? '0 : instrMem[rdPtr];
  assign q.head_exc   = isEmpty ? '0 : excMem[rdPtr];
  assign q.head_ds    = !isEmpty && dsMem[rdPtr];
  assign q.ds_missing = dsMissing;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int EW    = 8;

  typedef struct packed {
    logic [IW-1:0] pc;
    logic [IW-1:0] instr;
    logic [EW-1:0] exc;
    logic          ds;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ent_t mq[$];
  bit   mPend;
  bit   mMiss;

  inst_queue_if #(.DEPTH(DEPTH), .IW(IW), .EW(EW)) qi ();

  inst_queue #(.DEPTH(DEPTH), .IW(IW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic checkAll(input string t);
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk({t, ".count"}, 64'(qi.count), 64'(mq.size()));
    chk({t, ".empty"}, 64'(qi.empty), 64'(mq.size() == 0));
    chk({t, ".full"}, 64'(qi.full), 64'(mq.size() == DEPTH));
    chk({t, ".hvalid"}, 64'(qi.head_valid), 64'(mq.size() != 0));
    chk({t, ".hpc"}, 64'(qi.head_pc), 64'(h.pc));
    chk({t, ".hinstr"}, 64'(qi.head_instr), 64'(h.instr));
    chk({t, ".hexc"}, 64'(qi.head_exc), 64'(h.exc));
    chk({t, ".hds"}, 64'(qi.head_ds), 64'(h.ds));
    chk({t, ".dsmiss"}, 64'(qi.ds_missing), 64'(mMiss));
  endtask

  // Reference behaviour for one clock, expressed on the entry list.
  task automatic modelStep(input bit ps, input ent_t e, input bit pp, input bit fl, input bit rd);
    int   n;
    ent_t keep;
    n     = mq.size();
    mMiss = 1'b0;
    if (fl) begin
      mq.delete();
      mPend = 1'b0;
    end else if (rd && pp && n > 0) begin
      if (n >= 2) begin
        keep    = mq[1];
        keep.ds = 1'b1;
        mq.delete();
        mq.push_back(keep);
      end else if (ps) begin
        mq.delete();
        e.ds = 1'b1;
        mq.push_back(e);
        mPend = 1'b0;
      end else begin
        mq.delete();
        mMiss = 1'b1;
        mPend = 1'b1;
      end
    end else begin
      if (pp && n > 0) void'(mq.pop_front());
      if (ps && (n < DEPTH || pp)) begin
        e.ds = mPend;
        mq.push_back(e);
        mPend = 1'b0;
      end
    end
  endtask

  task automatic step(input string t, input bit ps, input logic [IW-1:0] pc,
                      input bit pp, input bit fl, input bit rd);
    ent_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'h5A5A_0F0F;
    e.exc   = pc[9:2];
    e.ds    = 1'b0;
    qi.push       = ps;
    qi.push_pc    = e.pc;
    qi.push_instr = e.instr;
    qi.push_exc   = e.exc;
    qi.pop        = pp;
    qi.flush      = fl;
    qi.redirect   = rd;
    @(posedge clk);
    #1;
    modelStep(ps, e, pp, fl, rd);
    checkAll(t);
  endtask

  initial begin
    qi.push = 0; qi.push_pc = '0; qi.push_instr = '0; qi.push_exc = '0;
    qi.pop = 0; qi.flush = 0; qi.redirect = 0;
    mPend = 0; mMiss = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then a dropped fifth push
    for (int i = 0; i < 4; i++) step("fill", 1, 32'hBFC0_0000 + 32'(4 * i), 0, 0, 0);
    chk("fill.full", 64'(qi.full), 64'd1);
    chk("fill.count", 64'(qi.count), 64'd4);
    step("drop5", 1, 32'hBFC0_0010, 0, 0, 0);
    chk("drop5.hpc", 64'(qi.head_pc), 64'hBFC0_0000);

    // Streaming at full across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step("stream", 1, 32'hBFC0_0010 + 32'(4 * i), 1, 0, 0);
      chk("stream.count", 64'(qi.count), 64'd4);
      chk("stream.hpc", 64'(qi.head_pc), 64'hBFC0_0000 + 64'(4 * (i + 1)));
    end
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 1, 0, 0);

    // Redirect with delay slot present
    step("r3a", 1, 32'h100, 0, 0, 0);
    step("r3b", 1, 32'h104, 0, 0, 0);
    step("r3c", 1, 32'h108, 0, 0, 0);
    step("redir", 0, 0, 1, 0, 1);
    chk("redir.count", 64'(qi.count), 64'd1);
    chk("redir.hpc", 64'(qi.head_pc), 64'h104);
    chk("redir.hds", 64'(qi.head_ds), 64'd1);
    step("flush1", 0, 0, 0, 1, 0);

    // Redirect with missing delay slot
    step("m1", 1, 32'h200, 0, 0, 0);
    step("miss", 0, 0, 1, 0, 1);
    chk("miss.empty", 64'(qi.empty), 64'd1);
    chk("miss.pulse", 64'(qi.ds_missing), 64'd1);
    step("missIdle", 0, 0, 0, 0, 0);
    chk("missIdle.pulse", 64'(qi.ds_missing), 64'd0);
    step("dsPush", 1, 32'h204, 0, 0, 0);
    chk("dsPush.hds", 64'(qi.head_ds), 64'd1);
    step("flush2", 0, 0, 0, 1, 0);

    // Flush overriding push and pop
    for (int i = 0; i < 3; i++) step("f3", 1, 32'h300 + 32'(4 * i), 0, 0, 0);
    step("flushAll", 1, 32'h30C, 1, 1, 0);
    chk("flushAll.empty", 64'(qi.empty), 64'd1);
    chk("flushAll.count", 64'(qi.count), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit ps, pp, fl, rd;
      ps = ($urandom_range(0, 9) < 6);
      pp = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 99) < 3);
      rd = ($urandom_range(0, 9) < 1);
      step("rand", ps, $urandom, pp, fl, rd);
    end

    // Asynchronous reset between edges
    step("pre1", 1, 32'h400, 0, 0, 0);
    step("pre2", 1, 32'h404, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    mq.delete();
    mPend = 0;
    mMiss = 0;
    chk("arst.empty", 64'(qi.empty), 64'd1);
    chk("arst.hinstr", 64'(qi.head_instr), 64'd0);
    checkAll("arst");
    @(negedge clk);
    rst = 1'b0;
    step("post", 1, 32'h500, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
